// File: rtl/hamming_serial_rx.sv
// Framed serial receiver feeding the Hamming decoder: start bit, N-bit codeword LSB first,
// stop bit; presents each good codeword on a valid/ready register with error flags.
module hamming_serial_rx #(
    parameter int unsigned P     = 3,
    parameter int unsigned CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  bit_en,
    input  logic                  serial_in,
    output logic [2**P-2:0]       rx_msg,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  frame_err,
    output logic                  overrun,
    input  logic                  clear_err,
    output logic [CNT_W-1:0]      frame_cnt
);

    localparam int unsigned N = 2**P - 1;
    localparam logic [P-1:0] IdxLast = P'(N - 1);

    typedef enum logic [1:0] {StIdle, StData, StStop} state_e;

    state_e           state_q, state_d;
    logic [P-1:0]     idx_q, idx_d;
    logic [N-1:0]     shift_q, shift_d;
    logic [N-1:0]     msg_q, msg_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             ovr_q, ovr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            shift_q <= '0;
            msg_q   <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            msg_q   <= msg_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        msg_d   = msg_q;
        valid_d = valid_q;
        ferr_d  = ferr_q;
        ovr_d   = ovr_q;
        cnt_d   = cnt_q;

        if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end
        // Error events below override a same-cycle clear.
        if (clear_err) begin
            ferr_d = 1'b0;
            ovr_d  = 1'b0;
        end

        if (bit_en) begin
            unique case (state_q)
                StIdle: begin
                    if (!serial_in) begin
                        state_d = StData;
                        idx_d   = '0;
                    end
                end
                StData: begin
                    shift_d[idx_q] = serial_in;
                    if (idx_q == IdxLast) begin
                        state_d = StStop;
                    end else begin
                        idx_d = idx_q + P'(1);
                    end
                end
                StStop: begin
                    state_d = StIdle;
                    if (serial_in) begin
                        // Output register counts as free if it drains this same cycle.
                        if (!valid_q || rx_ready) begin
                            msg_d   = shift_q;
                            valid_d = 1'b1;
                            cnt_d   = cnt_q + CNT_W'(1);
                        end else begin
                            ovr_d = 1'b1;
                        end
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign rx_msg    = msg_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;
    assign frame_cnt = cnt_q;

endmodule
